// File: rtl/horner_seq.sv
// horner_seq -- iterative polynomial evaluator using Horner's rule.
//
// Evaluates p(t) = c_D*t^D + ... + c_1*t + c_0. Each Horner step sends one
// pair (c0 = c_k, c1 = acc) through a pipelined multiply-add
// (y = c0 + c1*t, 3-cycle latency). The result becomes the new accumulator.
// All values are signed fixed point:
//   coefficients Q1.(BC-1), argument Q1.(BT-1), result Q1.(BY-1).
//
// Build option: define HORNER_SEQ_SAT_EN to saturate the multiply-add sum
// on signed overflow. If it is not defined, the sum wraps. Latency is the
// same in both builds.
//
// Ports:
//   clk      single clock; all logic is on the rising edge
//   rst      synchronous, active-high reset
//   c_we     coefficient write strobe (dropped while c_busy is high)
//   c_addr   coefficient index k
//   c_data   coefficient value c_k
//   c_busy   high while an evaluation is in progress
//   deg      polynomial degree D, sampled at the input handshake
//   s_valid  argument valid
//   s_ready  argument ready; s_valid & s_ready accepts s_t
//   s_t      argument t
//   m_valid  result valid
//   m_ready  downstream ready
//   m_y      result p(t), held stable until m_ready
module horner_seq #(
  parameter int BC = 16,
  parameter int BT = 16,
  parameter int BY = 16,
  parameter int N  = 7
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       c_we,
  input  logic [$clog2(N+1)-1:0]     c_addr,
  input  logic [BC-1:0]              c_data,
  output logic                       c_busy,
  input  logic [$clog2(N+1)-1:0]     deg,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [BT-1:0]              s_t,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [BY-1:0]              m_y
);

  localparam int AW = $clog2(N+1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t                state_q, state_d;
  logic                  live_q;     // clears during reset and holds s_ready low
  logic [AW-1:0]         k_q;
  logic [BT-1:0]         t_q;
  logic [BY-1:0]         acc_q;
  logic [1:0]            wcnt_q;
  logic [AW-1:0]         d_eff;
  logic                  handshake;
  logic [BC-1:0]         coef [0:N];

  // Datapath pipeline registers
  logic signed [BC-1:0]  dp_c0_q, dp_c1_q, dp_c0_q2;
  logic signed [BT-1:0]  dp_t_q;
  logic [BY-1:0]         prod_q;
  logic [BY-1:0]         y_q;
  logic [BY-1:0]         c0_al;
  logic [BY-1:0]         sum;

  // A degree above N is treated as N. The decoder loop avoids comparing
  // deg against a constant that may be its maximum value.
  always_comb begin
    d_eff = AW'(N);
    for (int i = 0; i <= N; i++)
      if (deg == AW'(i)) d_eff = AW'(i);
  end

  // NOTE: each signal written in always_comb gets a default at the top.
  // Without the default, some path leaves the signal unassigned and a latch is inferred.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b0;
    m_valid = 1'b0;
    c_busy  = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        s_ready = live_q;
        if (s_valid && live_q)
          state_d = (d_eff == '0) ? S_OUT : S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (wcnt_q == 2'd2)
          state_d = (k_q == '0) ? S_OUT : S_ISSUE;
      end
      S_OUT: begin
        m_valid = 1'b1;
        if (m_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign handshake = s_valid & s_ready;
  assign m_y       = acc_q;

  // NOTE: sequential blocks use non-blocking (<=) assignments only.
  // Then every register samples the values from before the edge, in any order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      live_q  <= 1'b1;
    end
  end

  // Control registers and the accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      k_q    <= '0;
      t_q    <= '0;
      wcnt_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (handshake) begin
            t_q   <= s_t;
            acc_q <= BY'(coef[d_eff]) << (BY - BC);  // c_D in the top BC bits
            k_q   <= d_eff - AW'(1);                 // unused when D = 0
          end
        end
        S_ISSUE: wcnt_q <= '0;
        S_WAIT: begin
          wcnt_q <= wcnt_q + 2'd1;
          if (wcnt_q == 2'd2) begin
            acc_q <= y_q;
            if (k_q != '0) k_q <= k_q - AW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // NOTE: the coefficient table resets because reset must clear it. The
  // datapath pipeline does not reset: the FSM reads it only 3 cycles after an issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= N; i++) coef[i] <= '0;
    end else if (c_we && !c_busy) begin
      // Only an in-range index matches, so other addresses are ignored.
      for (int i = 0; i <= N; i++)
        if (c_addr == AW'(i)) coef[i] <= c_data;
    end
  end

  // Datapath. The pipeline runs every cycle. The value the FSM takes in the
  // third WAIT cycle is the pair it presented during ISSUE.
  always_ff @(posedge clk) begin
    // stage 1: operands
    dp_c0_q  <= coef[k_q];
    dp_c1_q  <= acc_q[BY-1 -: BC];
    dp_t_q   <= t_q;
    // stage 2: full signed product. Keep bits [BC+BT-2 -: BY], which drops
    // the redundant sign bit and truncates the low bits.
    prod_q   <= BY'(((BC+BT)'(dp_c1_q) * (BC+BT)'(dp_t_q)) >>> (BC + BT - 1 - BY));
    dp_c0_q2 <= dp_c0_q;
    // stage 3: aligned add
    y_q      <= sum;
  end

  assign c0_al = BY'(dp_c0_q2) << (BY - BC);

`ifdef HORNER_SEQ_SAT_EN
  logic [BY:0] sum_ext;
  always_comb begin
    sum_ext = {prod_q[BY-1], prod_q} + {c0_al[BY-1], c0_al};
    sum     = sum_ext[BY-1:0];
    // The sum overflows when the two top bits of the extended sum differ.
    if (sum_ext[BY] != sum_ext[BY-1])
      sum = sum_ext[BY] ? {1'b1, {(BY-1){1'b0}}} : {1'b0, {(BY-1){1'b1}}};
  end
`else
  assign sum = prod_q + c0_al;
`endif

endmodule

// File: tb/tb_horner_seq.sv
// tb_horner_seq -- directed, table-driven bench for horner_seq. It uses the
// default parameters BC = BT = BY = 16 and N = 7. The expected values are
// worked out by hand in Q1.15.
module tb_horner_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        c_we;
  logic [2:0]  c_addr;
  logic [15:0] c_data;
  logic        c_busy;
  logic [2:0]  deg;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_t;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_y;

  int n_vec = 0;
  int n_bad = 0;

`ifdef HORNER_SEQ_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  horner_seq dut (
    .clk     (clk),
    .rst     (rst),
    .c_we    (c_we),
    .c_addr  (c_addr),
    .c_data  (c_data),
    .c_busy  (c_busy),
    .deg     (deg),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_t     (s_t),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_y     (m_y)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [127:0] c;     // {c7, c6, ..., c0}
    logic [2:0]   d;
    logic [15:0]  t;
    logic [15:0]  y;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  function automatic vec_t mk(string name, logic [127:0] c, logic [2:0] d,
                              logic [15:0] t, logic [15:0] y, int lat);
    vec_t v;
    v.name = name; v.c = c; v.d = d; v.t = t; v.y = y; v.lat = lat;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // All tasks start and return #1 after a rising edge.
  task automatic write_coef(logic [2:0] a, logic [15:0] v);
    c_we = 1'b1; c_addr = a; c_data = v;
    @(posedge clk); #1;
    c_we = 1'b0;
  endtask

  // Apply one argument. On return the handshake edge has passed, which makes
  // this cycle 1. deg and s_t are then changed to garbage so that latching is exercised.
  task automatic start_eval(string name, logic [2:0] d, logic [15:0] t);
    int guard = 0;
    while (!s_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check({name, ".ready"}, 32'(s_ready), 32'd1);
    s_valid = 1'b1; deg = d; s_t = t;
    @(posedge clk); #1;
    s_valid = 1'b0; deg = 3'd5; s_t = 16'hFFFF;
  endtask

  // Bounded wait for m_valid. lat returns the cycle number, counting the
  // handshake as cycle 0. A timeout shows up as a latency miscompare.
  task automatic wait_valid(input int lat0, output int lat);
    lat = lat0;
    while (!m_valid && lat < 60) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic release_out();
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
  endtask

  initial begin
    int lat;
    bit ok;
    bit seen;

    rst = 1'b1; c_we = 1'b0; c_addr = '0; c_data = '0;
    deg = '0; s_valid = 1'b0; s_t = '0; m_ready = 1'b0;

    vecs[0] = mk("lin",    {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4000, 16'h1000},
                 3'd1, 16'h4000, 16'h3000, 5);
    vecs[1] = mk("quad",   {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h4000, 16'h0, 16'h0},
                 3'd2, 16'h4000, 16'h1000, 9);
    vecs[2] = mk("d0",     {16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8001},
                 3'd0, 16'h1234, 16'h8001, 1);
    vecs[3] = mk("ovf_pos", {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h7FFF, 16'h7FFF},
                 3'd1, 16'h7FFF, SAT ? 16'h7FFF : 16'hFFFD, 5);
    vecs[4] = mk("d7_t0",  {16'h7FFF, 16'h1234, 16'h8000, 16'h4321, 16'h0F0F, 16'hAAAA, 16'h5555, 16'h0123},
                 3'd7, 16'h0000, 16'h0123, 29);
    vecs[5] = mk("neg",    {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hC000, 16'h0000},
                 3'd1, 16'h4000, 16'hE000, 5);
    vecs[6] = mk("m1xm1",  {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h0000},
                 3'd1, 16'h8000, 16'h8000, 5);
    vecs[7] = mk("ovf_neg", {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h8000, 16'h8000},
                 3'd1, 16'h4000, SAT ? 16'h8000 : 16'h4000, 5);
    vecs[8] = mk("cubic",  {16'h0, 16'h0, 16'h0, 16'h0, 16'h2000, 16'h2000, 16'h2000, 16'h2000},
                 3'd3, 16'h4000, 16'h3C00, 13);
    vecs[9] = mk("quad_n", {16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'hE000, 16'h4000, 16'h1000},
                 3'd2, 16'h8000, 16'hE000, 9);
    // quad_n: t = -1, acc = -0.25 -> 0.25 + 0.5 = 0.75 -> -0.75 + 0.125 = -0.625 = 0xB000?
    // Worked out: step1 (-0.25)(-1) + 0.5 = 0.75 = 0x6000; step2 (0.75)(-1) + 0.125 = -0.625.
    vecs[9].y = 16'hB000;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst.s_ready", 32'(s_ready), 32'd0);
    check("rst.m_valid", 32'(m_valid), 32'd0);
    check("rst.m_y",     32'(m_y),     32'd0);
    check("rst.c_busy",  32'(c_busy),  32'd0);
    rst = 1'b0;
    check("rst.s_ready_low_until_edge", 32'(s_ready), 32'd0);
    @(posedge clk); #1;
    check("rst.s_ready_rise", 32'(s_ready), 32'd1);

    // Table-driven vectors
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 8; k++) write_coef(3'(k), vecs[i].c[k*16 +: 16]);
      start_eval(vecs[i].name, vecs[i].d, vecs[i].t);
      wait_valid(1, lat);
      check({vecs[i].name, ".lat"}, 32'(lat), 32'(vecs[i].lat));
      check({vecs[i].name, ".y"},   32'(m_y), 32'(vecs[i].y));
      release_out();
    end

    // Backpressure in OUT, and a coefficient write attempted while busy
    write_coef(3'd0, 16'h1000);
    write_coef(3'd1, 16'h4000);
    start_eval("hold", 3'd1, 16'h4000);
    check("hold.c_busy", 32'(c_busy), 32'd1);
    write_coef(3'd0, 16'h5555);           // must be dropped
    wait_valid(2, lat);
    check("hold.lat", 32'(lat), 32'd5);
    ok = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (m_y !== 16'h3000 || m_valid !== 1'b1 || s_ready !== 1'b0) ok = 1'b0;
      @(posedge clk); #1;
    end
    check("hold.stable", 32'(ok), 32'd1);
    check("hold.y", 32'(m_y), 32'h3000);
    release_out();
    start_eval("readback", 3'd0, 16'h0000);
    wait_valid(1, lat);
    check("readback.lat", 32'(lat), 32'd1);
    check("readback.c0",  32'(m_y), 32'h1000);
    release_out();

    // Reset in the middle of a D = 3 run
    write_coef(3'd3, 16'h2000);
    write_coef(3'd2, 16'h2000);
    write_coef(3'd1, 16'h2000);
    write_coef(3'd0, 16'h2000);
    start_eval("rstwait", 3'd3, 16'h4000);
    @(posedge clk); #1;                   // cycle 2: WAIT
    check("rstwait.in_wait", 32'(c_busy), 32'd1);
    seen = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      if (m_valid) seen = 1'b1;
    end
    check("rstwait.s_ready_in_rst", 32'(s_ready), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("rstwait.s_ready_after", 32'(s_ready), 32'd1);
    for (int i = 0; i < 40; i++) begin
      if (m_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check("rstwait.no_m_valid", 32'(seen), 32'd0);
    start_eval("post_rst", 3'd0, 16'h4000);
    wait_valid(1, lat);
    check("post_rst.lat", 32'(lat), 32'd1);
    check("post_rst.y",   32'(m_y), 32'h0000);
    release_out();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
